// File: rtl/uart_mem_master.sv
// Byte-stream command bridge: 'W'/'R' commands from a UART RX stream become single
// 32-bit transactions on the packed MEM bus; ACK/NAK or read data go back on TX.
module uart_mem_master #(
  parameter int BUS_TIMEOUT  = 1024,
  parameter int BYTE_TIMEOUT = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_tdata,
  input  logic        rx_tvalid,
  output logic        rx_tready,
  output logic [7:0]  tx_tdata,
  output logic        tx_tvalid,
  input  logic        tx_tready,
  output logic [68:0] mem_packed_fwd,
  input  logic [32:0] mem_packed_ret,
  output logic        busy,
  output logic        err_pulse
);

  localparam int BUS_W  = $clog2(BUS_TIMEOUT + 1);
  localparam int BYTE_W = (BYTE_TIMEOUT > 1) ? $clog2(BYTE_TIMEOUT + 1) : 1;
  localparam logic [BUS_W-1:0]  BUS_LAST  = BUS_W'(BUS_TIMEOUT - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BYTE_TIMEOUT - 1);
  localparam logic [7:0] OP_W = 8'h57;
  localparam logic [7:0] OP_R = 8'h52;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NAK  = 8'h15;

  typedef enum logic [2:0] {S_IDLE, S_RX_ADDR, S_RX_DATA, S_BUS, S_TX_RESP} state_t;

  state_t              state_q, state_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [1:0]          resp_last_q, resp_last_d;
  logic                is_wr_q, is_wr_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         resp_q, resp_d;
  logic [BUS_W-1:0]    bus_cnt_q, bus_cnt_d;
  logic [BYTE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic                err_q, err_d;
  logic                busy_q;
  logic                rx_rdy_q;

  logic rx_xfer, tx_xfer, mem_ready, bus_to, byte_to, op_ok;

  assign rx_xfer   = rx_tvalid && rx_rdy_q;
  assign tx_xfer   = tx_tvalid && tx_tready;
  assign mem_ready = mem_packed_ret[32];
  assign bus_to    = (bus_cnt_q == BUS_LAST);
  assign byte_to   = (BYTE_TIMEOUT != 0) && (idle_cnt_q == BYTE_LAST);
  assign op_ok     = (rx_tdata == OP_W) || (rx_tdata == OP_R);

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // A completing transfer always takes priority over a timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (rx_xfer) state_d = op_ok ? S_RX_ADDR : S_TX_RESP;
      S_RX_ADDR: begin
        if (rx_xfer && byte_cnt_q == 2'd3) state_d = is_wr_q ? S_RX_DATA : S_BUS;
        else if (!rx_xfer && byte_to)      state_d = S_IDLE;
      end
      S_RX_DATA: begin
        if (rx_xfer && byte_cnt_q == 2'd3) state_d = S_BUS;
        else if (!rx_xfer && byte_to)      state_d = S_IDLE;
      end
      S_BUS:     if (mem_ready || bus_to) state_d = S_TX_RESP;
      S_TX_RESP: if (tx_xfer && byte_cnt_q == resp_last_q) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_packed_fwd = '0;
    tx_tvalid      = 1'b0;
    tx_tdata       = 8'h00;
    if (state_q == S_BUS)
      mem_packed_fwd = {is_wr_q ? wdata_q : 32'h0, is_wr_q ? 4'hF : 4'h0, 1'b1, addr_q};
    if (state_q == S_TX_RESP) begin
      tx_tvalid = 1'b1;
      tx_tdata  = resp_q[31:24];
    end
  end

  assign rx_tready = rx_rdy_q;
  assign busy      = busy_q;
  assign err_pulse = err_q;

  always_comb begin
    byte_cnt_d  = byte_cnt_q;
    resp_last_d = resp_last_q;
    is_wr_d     = is_wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    resp_d      = resp_q;
    bus_cnt_d   = '0;
    idle_cnt_d  = '0;
    err_d       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        byte_cnt_d = 2'd0;
        if (rx_xfer) begin
          is_wr_d = (rx_tdata == OP_W);
          if (!op_ok) begin
            resp_d      = {NAK, 24'h0};
            resp_last_d = 2'd0;
            err_d       = 1'b1;
          end
        end
      end
      S_RX_ADDR, S_RX_DATA: begin
        if (rx_xfer) begin
          if (state_q == S_RX_ADDR) addr_d  = {addr_q[23:0], rx_tdata};
          else                      wdata_d = {wdata_q[23:0], rx_tdata};
          byte_cnt_d = byte_cnt_q + 2'd1;
        end else begin
          idle_cnt_d = idle_cnt_q + BYTE_W'(1);
          err_d      = byte_to;
        end
      end
      S_BUS: begin
        bus_cnt_d  = bus_cnt_q + BUS_W'(1);
        byte_cnt_d = 2'd0;
        if (mem_ready) begin
          resp_d      = is_wr_q ? {ACK, 24'h0} : mem_packed_ret[31:0];
          resp_last_d = is_wr_q ? 2'd0 : 2'd3;
        end else if (bus_to) begin
          resp_d      = {NAK, 24'h0};
          resp_last_d = 2'd0;
          err_d       = 1'b1;
        end
      end
      S_TX_RESP: begin
        if (tx_xfer) begin
          resp_d     = {resp_q[23:0], 8'h00};
          byte_cnt_d = byte_cnt_q + 2'd1;
        end
      end
      default: byte_cnt_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      byte_cnt_q  <= '0;
      resp_last_q <= '0;
      is_wr_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      resp_q      <= '0;
      bus_cnt_q   <= '0;
      idle_cnt_q  <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      rx_rdy_q    <= 1'b0;
    end else begin
      byte_cnt_q  <= byte_cnt_d;
      resp_last_q <= resp_last_d;
      is_wr_q     <= is_wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      resp_q      <= resp_d;
      bus_cnt_q   <= bus_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      err_q       <= err_d;
      busy_q      <= (state_d != S_IDLE);
      rx_rdy_q    <= (state_d == S_IDLE) || (state_d == S_RX_ADDR) || (state_d == S_RX_DATA);
    end
  end

endmodule

// File: tb/tb_uart_mem_master.sv
// Bench for uart_mem_master: command tasks feed a reply/bus-beat model, and one negedge
// process plays slave and sink while checking every DUT output against it.
module tb_uart_mem_master;
  localparam int BUS_TO  = 16;
  localparam int BYTE_TO = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_tdata = 8'h00;
  logic        rx_tvalid = 1'b0;
  logic        rx_tready;
  logic [7:0]  tx_tdata;
  logic        tx_tvalid;
  logic        tx_tready;
  logic [68:0] mem_packed_fwd;
  logic [32:0] mem_packed_ret;
  logic        busy;
  logic        err_pulse;

  always #5 clk = ~clk;

  uart_mem_master #(.BUS_TIMEOUT(BUS_TO), .BYTE_TIMEOUT(BYTE_TO)) dut (
    .clk(clk), .rst(rst),
    .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tready(rx_tready),
    .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
    .mem_packed_fwd(mem_packed_fwd), .mem_packed_ret(mem_packed_ret),
    .busy(busy), .err_pulse(err_pulse)
  );

  wire mem_valid = mem_packed_fwd[32];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  wstrb;
    int          delay;  // 0 = no responder
  } beat_t;

  beat_t      beat_q[$];
  logic [7:0] exp_tx[$];
  logic [7:0] tx_log[$];
  int n_cmp = 0;
  int n_bad = 0;
  int err_cnt = 0;
  int exp_err = 0;
  logic tx_toggle = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %h, nothing expected", name, act);
  endtask

  // Slave, sink and per-cycle checker.
  int    vcnt = 0;
  logic  prev_valid = 1'b0;
  logic  hold = 1'b0;
  logic [7:0] hold_data = 8'h00;
  beat_t b;
  always @(negedge clk) begin
    if (!rst) begin
      beat_q.delete();
      exp_tx.delete();
      vcnt = 0;
      prev_valid = 1'b0;
      hold = 1'b0;
      tx_tready = 1'b0;
      mem_packed_ret = '0;
    end else begin
      tx_tready = tx_toggle ? !tx_tready : 1'b1;
      if (hold) begin
        chk("tx_hold_valid", 32'(tx_tvalid), 32'd1);
        chk("tx_hold_data", 32'(tx_tdata), 32'(hold_data));
      end
      if (tx_tvalid && tx_tready) begin
        tx_log.push_back(tx_tdata);
        $display("tx byte %h", tx_tdata);
        if (exp_tx.size() == 0) fail_now("tx_unexpected_byte", 32'(tx_tdata));
        else chk("tx_byte", 32'(tx_tdata), 32'(exp_tx.pop_front()));
      end
      hold = tx_tvalid && !tx_tready;
      hold_data = tx_tdata;
      chk("rx_blocked_when_active", 32'(rx_tready && (mem_valid || tx_tvalid)), 32'd0);
      chk("busy_when_active", 32'(!busy && (mem_valid || tx_tvalid)), 32'd0);
      if (err_pulse) err_cnt++;
      if (mem_valid) begin
        if (beat_q.size() == 0) begin
          fail_now("unexpected_beat", mem_packed_fwd[31:0]);
          mem_packed_ret = '0;
        end else begin
          b = beat_q[0];
          vcnt++;
          chk("beat_addr", mem_packed_fwd[31:0], b.addr);
          chk("beat_wdata", mem_packed_fwd[68:37], b.wdata);
          chk("beat_wstrb", 32'(mem_packed_fwd[36:33]), 32'(b.wstrb));
          mem_packed_ret = {(b.delay != 0 && vcnt == b.delay), b.rdata};
        end
        prev_valid = 1'b1;
      end else begin
        if (prev_valid && beat_q.size() != 0) begin
          b = beat_q.pop_front();
          chk("valid_cycles", 32'(vcnt), 32'(b.delay != 0 ? b.delay : BUS_TO));
          $display("bus beat addr=%h wdata=%h wstrb=%h cycles=%0d", b.addr, b.wdata, b.wstrb, vcnt);
        end
        vcnt = 0;
        prev_valid = 1'b0;
        mem_packed_ret = {1'b1, 32'hBADBAD00};  // stray ready while idle must be ignored
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] v);
    int n = 0;
    rx_tdata = v;
    rx_tvalid = 1'b1;
    while (!rx_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail_now("rx_accept_timeout", 32'(v));
    @(negedge clk);
    rx_tvalid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  task automatic cmd_w(input logic [31:0] a, input logic [31:0] d, input int dly);
    beat_q.push_back('{addr: a, wdata: d, rdata: 32'h0, wstrb: 4'hF, delay: dly});
    if (dly != 0) exp_tx.push_back(8'h06);
    else begin exp_tx.push_back(8'h15); exp_err++; end
    send_byte(8'h57);
    send_word(a);
    send_word(d);
  endtask

  task automatic cmd_r(input logic [31:0] a, input logic [31:0] rd, input int dly);
    beat_q.push_back('{addr: a, wdata: 32'h0, rdata: rd, wstrb: 4'h0, delay: dly});
    if (dly != 0) for (int i = 3; i >= 0; i--) exp_tx.push_back(rd[8*i +: 8]);
    else begin exp_tx.push_back(8'h15); exp_err++; end
    send_byte(8'h52);
    send_word(a);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_tx.size() != 0 || beat_q.size() != 0 || busy || tx_tvalid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) fail_now({name, "_done_timeout"}, 32'(exp_tx.size()));
    chk({name, "_err_count"}, 32'(err_cnt), 32'(exp_err));
  endtask

  task automatic chk_log(input string name, input int len, input logic [31:0] exp);
    logic [31:0] got = 32'h0;
    chk({name, "_len"}, 32'(tx_log.size()), 32'(len));
    foreach (tx_log[i]) got = {got[23:0], tx_log[i]};
    chk({name, "_bytes"}, got, exp);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rx_tready", 32'(rx_tready), 32'd0);
    chk("rst_tx_tvalid", 32'(tx_tvalid), 32'd0);
    chk("rst_tx_tdata", 32'(tx_tdata), 32'd0);
    chk("rst_fwd_lo", mem_packed_fwd[31:0], 32'd0);
    chk("rst_fwd_hi", 32'(mem_packed_fwd[68:32]), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_pulse), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("release_rx_tready", 32'(rx_tready), 32'd1);
    @(negedge clk);

    tx_log.delete();
    cmd_w(32'h0000_0010, 32'hDEAD_BEEF, 3);
    wait_done("write");
    chk_log("write_reply", 1, 32'h0000_0006);

    tx_log.delete();
    cmd_r(32'h0000_0008, 32'h0000_00A5, 2);
    wait_done("read");
    chk_log("read_reply", 4, 32'h0000_00A5);

    tx_log.delete();
    exp_tx.push_back(8'h15);
    exp_err++;
    send_byte(8'h41);
    wait_done("bad_op");
    chk_log("bad_op_reply", 1, 32'h0000_0015);
    tx_log.delete();
    cmd_r(32'h0000_0020, 32'h1234_5678, 1);
    wait_done("read_after_bad");
    chk_log("read_after_bad_reply", 4, 32'h1234_5678);

    tx_log.delete();
    cmd_r(32'h0000_FFF0, 32'h0, 0);
    wait_done("bus_timeout");
    chk_log("bus_timeout_reply", 1, 32'h0000_0015);
    tx_log.delete();
    cmd_w(32'h0000_0004, 32'h0102_0304, 1);
    wait_done("write_after_bus_to");
    chk_log("write_after_bus_to_reply", 1, 32'h0000_0006);

    tx_log.delete();
    send_byte(8'h57);
    send_byte(8'h00);
    send_byte(8'h00);
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("byte_timeout_cycles", 32'(n), 32'd100);
    exp_err++;
    repeat (3) @(negedge clk);
    chk("byte_timeout_err", 32'(err_cnt), 32'(exp_err));
    chk("byte_timeout_no_reply", 32'(tx_log.size()), 32'd0);
    cmd_w(32'h0000_0100, 32'hCAFE_F00D, 2);
    wait_done("write_after_byte_to");
    chk_log("write_after_byte_to_reply", 1, 32'h0000_0006);

    tx_log.delete();
    tx_toggle = 1'b1;
    cmd_r(32'h0000_000C, 32'h1122_3344, 2);
    wait_done("read_toggle");
    tx_toggle = 1'b0;
    chk_log("read_toggle_reply", 4, 32'h1122_3344);

    tx_log.delete();
    beat_q.push_back('{addr: 32'h30, wdata: 32'h0, rdata: 32'h0, wstrb: 4'h0, delay: 0});
    send_byte(8'h52);
    send_word(32'h0000_0030);
    n = 0;
    while (!mem_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reset_test_valid_seen", 32'(mem_valid), 32'd1);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_mem_valid", 32'(mem_valid), 32'd0);
    chk("midrst_tx_tvalid", 32'(tx_tvalid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rx_tready", 32'(rx_tready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_release_rx_tready", 32'(rx_tready), 32'd1);
    repeat (20) @(negedge clk);
    chk("midrst_no_reply", 32'(tx_log.size()), 32'd0);
    cmd_r(32'h0000_0034, 32'h0BAD_CAFE, 1);
    wait_done("read_after_reset");
    chk_log("read_after_reset_reply", 4, 32'h0BAD_CAFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end
endmodule
